// File: rtl/cnn_relu_pool_if.sv
// cnn_relu_pool_if: sample stream into, and pooled stream out of, cnn_relu_pool.
// master = upstream conv producer / consumer side, slave = the pooling stage.
interface cnn_relu_pool_if;
  logic        enable;
  logic        conv_valid;
  logic [18:0] convolution;
  logic [7:0]  pool_out;
  logic        pool_valid;
  logic        frame_done;

  modport master (
    output enable, conv_valid, convolution,
    input  pool_out, pool_valid, frame_done
  );

  modport slave (
    input  enable, conv_valid, convolution,
    output pool_out, pool_valid, frame_done
  );
endinterface

// File: rtl/cnn_relu_pool.sv
// cnn_relu_pool: ReLU -> 2x2/stride-2 max pool -> 8-bit requantize on a raster conv stream.
// Optional build macro CNN_POOL_ROUND_EN selects round-half-up instead of truncation.
module cnn_relu_pool #(
  parameter int unsigned MAP_W = 4,
  parameter int unsigned MAP_H = 4,
  parameter int unsigned SHIFT = 4
) (
  input logic           clock,
  input logic           reset,
  cnn_relu_pool_if.slave bus
);

  // Line buffer depth is rounded up to a power of two so the index width matches exactly.
  localparam int unsigned IdxW = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;
  localparam int unsigned ColW = IdxW + 1;
  localparam int unsigned RowW = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int unsigned BufD = 2 ** IdxW;

`ifdef CNN_POOL_ROUND_EN
  localparam logic [19:0] Rnd = 20'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
`else
  localparam logic [19:0] Rnd = 20'd0;
`endif

  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic [17:0]     r_h;
  logic [17:0]     r_buf [BufD];
  logic [7:0]      r_pool_out;
  logic            r_pool_valid;
  logic            r_frame_done;

  logic            w_accept;
  logic            w_col_last;
  logic            w_row_last;
  logic            w_fire;
  logic [IdxW-1:0] w_idx;
  logic [17:0]     w_relu;
  logic [17:0]     w_p;
  logic [17:0]     w_m;
  logic [19:0]     w_sum;
  logic [19:0]     w_shifted;
  logic [7:0]      w_q;

  assign w_accept   = bus.enable & bus.conv_valid;
  assign w_col_last = (r_col == ColW'(MAP_W - 1));
  assign w_row_last = (r_row == RowW'(MAP_H - 1));
  assign w_idx      = r_col[ColW-1:1];
  // Bottom-right sample of a 2x2 window: odd row, odd column.
  assign w_fire     = w_accept & r_col[0] & r_row[0];

  assign w_relu    = bus.convolution[18] ? 18'd0 : bus.convolution[17:0];
  assign w_p       = (r_h > w_relu) ? r_h : w_relu;
  assign w_m       = (r_buf[w_idx] > w_p) ? r_buf[w_idx] : w_p;
  assign w_sum     = {2'b00, w_m} + Rnd;
  assign w_shifted = w_sum >> SHIFT;
  assign w_q       = (|w_shifted[19:8]) ? 8'hFF : w_shifted[7:0];

  // Raster position counters; wrap straight into the next frame with no idle cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Horizontal pair register and line buffer of even-row pair maxima.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_h <= '0;
      for (int i = 0; i < int'(BufD); i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      if (!r_col[0]) begin
        r_h <= w_relu;
      end else if (!r_row[0]) begin
        r_buf[w_idx] <= w_p;
      end
    end
  end

  // Registered outputs; pulses last one cycle, pool_out holds between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pool_out   <= '0;
      r_pool_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pool_valid <= w_fire;
      r_frame_done <= w_fire & w_col_last & w_row_last;
      if (w_fire) begin
        r_pool_out <= w_q;
      end
    end
  end

  assign bus.pool_out   = r_pool_out;
  assign bus.pool_valid = r_pool_valid;
  assign bus.frame_done = r_frame_done;

endmodule
